// File: rtl/qnet_cmd_arb.sv
// qnet_cmd_arb: round-robin arbiter between the local and network command
// request/ack pairs. It issues the granted command to the TX packet engine,
// tracks completion with a timeout and returns a four-phase ack.
// Ports:
//   t_clk_i, t_rst_ni         clock, synchronous active-low reset
//   loc_cmd_req_i/_ack_o      local requester handshake (level)
//   net_cmd_req_i/_ack_o      network requester handshake (level)
//   header_i, data_i          shared command payload
//   tx_vld_o/tx_rdy_i         issue handshake to the TX engine
//   tx_header_o, tx_data_o    latched payload
//   tx_done_i                 TX completion pulse
//   busy_o, grant_o           status (grant: 0=loc, 1=net)
//   cmd_cnt_o, err_cnt_o      completed / error counters
//   last_err_o                00 none, 01 invalid header, 10 timeout
module qnet_cmd_arb #(
   parameter int TIMEOUT_CYC = 4096,
   parameter int CNT_W       = 16
) (
   input  logic              t_clk_i,
   input  logic              t_rst_ni,
   input  logic              loc_cmd_req_i,
   input  logic              net_cmd_req_i,
   input  logic [63:0]       header_i,
   input  logic [1:0][31:0]  data_i,
   output logic              loc_cmd_ack_o,
   output logic              net_cmd_ack_o,
   output logic              tx_vld_o,
   input  logic              tx_rdy_i,
   output logic [63:0]       tx_header_o,
   output logic [1:0][31:0]  tx_data_o,
   input  logic              tx_done_i,
   output logic              busy_o,
   output logic              grant_o,
   output logic [CNT_W-1:0]  cmd_cnt_o,
   output logic [CNT_W-1:0]  err_cnt_o,
   output logic [1:0]        last_err_o
);

   // One spare bit so the timer can never wrap back below the limit
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACK
   } state_t;

   state_t             r_state;
   logic               r_vld;
   logic [63:0]        r_hdr;
   logic [1:0][31:0]   r_data;
   logic               r_loc_ack;
   logic               r_net_ack;
   logic               r_grant;
   logic [CNT_W-1:0]   r_cmd_cnt;
   logic [CNT_W-1:0]   r_err_cnt;
   logic [1:0]         r_last_err;
   logic [TW-1:0]      r_timer;

   logic               w_any;
   logic               w_pick_net;
   logic               w_gnt_req;
   logic               w_tmo;
   logic               w_hdr_bad;
   logic [CNT_W-1:0]   w_err_nxt;

   assign w_any      = loc_cmd_req_i | net_cmd_req_i;
   // Net wins when it is alone, or when both ask and loc went last
   assign w_pick_net = net_cmd_req_i & (~loc_cmd_req_i | ~r_grant);
   assign w_gnt_req  = r_grant ? net_cmd_req_i : loc_cmd_req_i;
   assign w_tmo      = (r_timer >= TW'(TIMEOUT_CYC - 1));
   assign w_hdr_bad  = (header_i[63:61] == 3'b000);
   assign w_err_nxt  = (r_err_cnt == {CNT_W{1'b1}}) ?
                       r_err_cnt : r_err_cnt + 1'b1;

   always_ff @(posedge t_clk_i) begin
      if (!t_rst_ni) begin
         r_state    <= S_IDLE;
         r_vld      <= 1'b0;
         r_hdr      <= '0;
         r_data     <= '0;
         r_loc_ack  <= 1'b0;
         r_net_ack  <= 1'b0;
         r_grant    <= 1'b1;
         r_cmd_cnt  <= '0;
         r_err_cnt  <= '0;
         r_last_err <= 2'b00;
         r_timer    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant <= w_pick_net;
                  r_hdr   <= header_i;
                  r_data  <= data_i;
                  r_timer <= '0;
                  if (w_hdr_bad) begin
                     r_state    <= S_ACK;
                     r_last_err <= 2'b01;
                     r_err_cnt  <= w_err_nxt;
                     r_loc_ack  <= ~w_pick_net;
                     r_net_ack  <= w_pick_net;
                  end else begin
                     r_state <= S_ISSUE;
                     r_vld   <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               r_timer <= r_timer + 1'b1;
               // Done in the accept cycle counts; accept beats timeout
               if (tx_rdy_i && tx_done_i) begin
                  r_state    <= S_ACK;
                  r_vld      <= 1'b0;
                  r_cmd_cnt  <= r_cmd_cnt + 1'b1;
                  r_last_err <= 2'b00;
                  r_loc_ack  <= ~r_grant;
                  r_net_ack  <= r_grant;
               end else if (tx_rdy_i) begin
                  r_state <= S_WAIT;
                  r_vld   <= 1'b0;
               end else if (w_tmo) begin
                  r_state    <= S_ACK;
                  r_vld      <= 1'b0;
                  r_err_cnt  <= w_err_nxt;
                  r_last_err <= 2'b10;
                  r_loc_ack  <= ~r_grant;
                  r_net_ack  <= r_grant;
               end
            end
            S_WAIT: begin
               r_timer <= r_timer + 1'b1;
               if (tx_done_i) begin
                  r_state    <= S_ACK;
                  r_cmd_cnt  <= r_cmd_cnt + 1'b1;
                  r_last_err <= 2'b00;
                  r_loc_ack  <= ~r_grant;
                  r_net_ack  <= r_grant;
               end else if (w_tmo) begin
                  r_state    <= S_ACK;
                  r_err_cnt  <= w_err_nxt;
                  r_last_err <= 2'b10;
                  r_loc_ack  <= ~r_grant;
                  r_net_ack  <= r_grant;
               end
            end
            S_ACK: begin
               if (!w_gnt_req) begin
                  r_state   <= S_IDLE;
                  r_loc_ack <= 1'b0;
                  r_net_ack <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_vld_o      = r_vld;
   assign tx_header_o   = r_hdr;
   assign tx_data_o     = r_data;
   assign loc_cmd_ack_o = r_loc_ack;
   assign net_cmd_ack_o = r_net_ack;
   assign busy_o        = (r_state != S_IDLE);
   assign grant_o       = r_grant;
   assign cmd_cnt_o     = r_cmd_cnt;
   assign err_cnt_o     = r_err_cnt;
   assign last_err_o    = r_last_err;

endmodule

// File: tb/tb_qnet_cmd_arb.sv
// tb_qnet_cmd_arb: directed bench for qnet_cmd_arb with a short
// timeout (8 cycles) and 4-bit counters.
module tb_qnet_cmd_arb;

   localparam int TMO = 8;
   localparam int CW  = 4;

   localparam logic [63:0] H1 = 64'h9000_0000_0000_0001;
   localparam logic [63:0] H2 = 64'hA000_0000_0000_00A1;
   localparam logic [63:0] H3 = 64'hC000_0000_0000_00B2;
   localparam logic [63:0] H4 = 64'hE000_0000_0000_00C3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             loc, net;
   logic [63:0]      hdr;
   logic [1:0][31:0] dat;
   logic             rdy, done;
   logic             loc_ack, net_ack, vld;
   logic [63:0]      tx_hdr;
   logic [1:0][31:0] tx_dat;
   logic             busy, grant;
   logic [CW-1:0]    cmd_cnt, err_cnt;
   logic [1:0]       last_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   qnet_cmd_arb #(.TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
      .t_clk_i       (clk),
      .t_rst_ni      (rst_n),
      .loc_cmd_req_i (loc),
      .net_cmd_req_i (net),
      .header_i      (hdr),
      .data_i        (dat),
      .loc_cmd_ack_o (loc_ack),
      .net_cmd_ack_o (net_ack),
      .tx_vld_o      (vld),
      .tx_rdy_i      (rdy),
      .tx_header_o   (tx_hdr),
      .tx_data_o     (tx_dat),
      .tx_done_i     (done),
      .busy_o        (busy),
      .grant_o       (grant),
      .cmd_cnt_o     (cmd_cnt),
      .err_cnt_o     (err_cnt),
      .last_err_o    (last_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      loc = 1'b0; net = 1'b0;
      rdy = 1'b0; done = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic run_good();
      loc = 1'b1; tick();
      rdy = 1'b1; tick();
      rdy = 1'b0; done = 1'b1; tick();
      done = 1'b0; loc = 1'b0; tick();
   endtask

   task automatic run_timeout();
      loc = 1'b1;
      repeat (TMO + 1) tick();
      loc = 1'b0; tick();
   endtask

   task automatic test_reset();
      hdr = H1; dat[0] = 32'h0; dat[1] = 32'h0;
      apply_reset();
      n_chk++;
      if (vld !== 1'b0) begin n_fail++;
         $display("FAIL rst_vld got %b exp 0", vld); end
      n_chk++;
      if ({loc_ack, net_ack} !== 2'b00) begin n_fail++;
         $display("FAIL rst_ack got %b exp 00", {loc_ack, net_ack}); end
      n_chk++;
      if (busy !== 1'b0) begin n_fail++;
         $display("FAIL rst_busy got %b exp 0", busy); end
      n_chk++;
      if (grant !== 1'b1) begin n_fail++;
         $display("FAIL rst_grant got %b exp 1", grant); end
      n_chk++;
      if ({cmd_cnt, err_cnt, last_err} !== 10'h0) begin n_fail++;
         $display("FAIL rst_cnt got %h exp 0", {cmd_cnt, err_cnt, last_err}); end
      n_chk++;
      if (tx_hdr !== 64'h0) begin n_fail++;
         $display("FAIL rst_hdr got %h exp 0", tx_hdr); end
   endtask

   task automatic test_local_only();
      apply_reset();
      hdr = H1; dat[0] = 32'h11; dat[1] = 32'h22;
      loc = 1'b1;
      tick(); // N+1
      n_chk++;
      if ({vld, busy, grant} !== 3'b110) begin n_fail++;
         $display("FAIL lo_issue got %b exp 110", {vld, busy, grant}); end
      n_chk++;
      if (tx_hdr !== H1) begin n_fail++;
         $display("FAIL lo_hdr got %h exp %h", tx_hdr, H1); end
      n_chk++;
      if (tx_dat !== {32'h22, 32'h11}) begin n_fail++;
         $display("FAIL lo_data got %h exp 0000002200000011", tx_dat); end
      tick(); // N+2
      n_chk++;
      if (vld !== 1'b1) begin n_fail++;
         $display("FAIL lo_vld2 got %b exp 1", vld); end
      tick(); // N+3
      n_chk++;
      if (vld !== 1'b1) begin n_fail++;
         $display("FAIL lo_vld3 got %b exp 1", vld); end
      rdy = 1'b1;
      tick(); // N+4
      rdy = 1'b0;
      n_chk++;
      if (vld !== 1'b0) begin n_fail++;
         $display("FAIL lo_vld4 got %b exp 0", vld); end
      tick(); // N+5
      tick(); // N+6
      n_chk++;
      if (loc_ack !== 1'b0) begin n_fail++;
         $display("FAIL lo_early_ack got %b exp 0", loc_ack); end
      done = 1'b1;
      tick(); // N+7
      done = 1'b0;
      n_chk++;
      if ({loc_ack, net_ack} !== 2'b10) begin n_fail++;
         $display("FAIL lo_ack got %b exp 10", {loc_ack, net_ack}); end
      n_chk++;
      if (cmd_cnt !== 4'd1) begin n_fail++;
         $display("FAIL lo_cmd_cnt got %0d exp 1", cmd_cnt); end
      tick(); // N+8, req still high
      n_chk++;
      if (loc_ack !== 1'b1) begin n_fail++;
         $display("FAIL lo_ack_hold got %b exp 1", loc_ack); end
      loc = 1'b0;
      tick();
      n_chk++;
      if ({loc_ack, busy, grant} !== 3'b000) begin n_fail++;
         $display("FAIL lo_release got %b exp 000", {loc_ack, busy, grant}); end
   endtask

   task automatic test_round_robin();
      apply_reset();
      hdr = H2; loc = 1'b1; net = 1'b1;
      tick();
      n_chk++;
      if ({grant, vld, net_ack} !== 3'b010) begin n_fail++;
         $display("FAIL rr_g1 got %b exp 010", {grant, vld, net_ack}); end
      n_chk++;
      if (tx_hdr !== H2) begin n_fail++;
         $display("FAIL rr_hdr1 got %h exp %h", tx_hdr, H2); end
      hdr = H3; rdy = 1'b1;
      tick();
      rdy = 1'b0; done = 1'b1;
      n_chk++;
      if (net_ack !== 1'b0) begin n_fail++;
         $display("FAIL rr_net_wait got %b exp 0", net_ack); end
      tick();
      done = 1'b0;
      n_chk++;
      if ({loc_ack, net_ack} !== 2'b10) begin n_fail++;
         $display("FAIL rr_ack1 got %b exp 10", {loc_ack, net_ack}); end
      loc = 1'b0;
      tick();
      n_chk++;
      if ({loc_ack, net_ack, busy} !== 3'b000) begin n_fail++;
         $display("FAIL rr_idle1 got %b exp 000", {loc_ack, net_ack, busy}); end
      loc = 1'b1;
      tick();
      n_chk++;
      if ({grant, vld} !== 2'b11) begin n_fail++;
         $display("FAIL rr_g2 got %b exp 11", {grant, vld}); end
      n_chk++;
      if (tx_hdr !== H3) begin n_fail++;
         $display("FAIL rr_hdr2 got %h exp %h", tx_hdr, H3); end
      hdr = H4; rdy = 1'b1;
      tick();
      rdy = 1'b0; done = 1'b1;
      tick();
      done = 1'b0;
      n_chk++;
      if ({loc_ack, net_ack} !== 2'b01) begin n_fail++;
         $display("FAIL rr_ack2 got %b exp 01", {loc_ack, net_ack}); end
      n_chk++;
      if (cmd_cnt !== 4'd2) begin n_fail++;
         $display("FAIL rr_cnt2 got %0d exp 2", cmd_cnt); end
      net = 1'b0;
      tick();
      net = 1'b1;
      tick();
      n_chk++;
      if ({grant, vld, net_ack} !== 3'b010) begin n_fail++;
         $display("FAIL rr_g3 got %b exp 010", {grant, vld, net_ack}); end
      n_chk++;
      if (tx_hdr !== H4) begin n_fail++;
         $display("FAIL rr_hdr3 got %h exp %h", tx_hdr, H4); end
      rdy = 1'b1;
      tick();
      rdy = 1'b0; done = 1'b1;
      tick();
      done = 1'b0;
      n_chk++;
      if ({loc_ack, net_ack} !== 2'b10) begin n_fail++;
         $display("FAIL rr_ack3 got %b exp 10", {loc_ack, net_ack}); end
      loc = 1'b0; net = 1'b0;
      tick();
   endtask

   task automatic test_invalid();
      apply_reset();
      hdr = 64'h0; loc = 1'b1;
      tick();
      n_chk++;
      if ({vld, loc_ack, busy} !== 3'b011) begin n_fail++;
         $display("FAIL inv_ack got %b exp 011", {vld, loc_ack, busy}); end
      n_chk++;
      if (last_err !== 2'b01) begin n_fail++;
         $display("FAIL inv_last_err got %b exp 01", last_err); end
      n_chk++;
      if ({err_cnt, cmd_cnt} !== {4'd1, 4'd0}) begin n_fail++;
         $display("FAIL inv_cnt got %h exp 10", {err_cnt, cmd_cnt}); end
      loc = 1'b0;
      tick();
      n_chk++;
      if ({loc_ack, busy, last_err} !== 4'b0001) begin n_fail++;
         $display("FAIL inv_release got %b exp 0001", {loc_ack, busy, last_err}); end
   endtask

   task automatic test_timeout();
      apply_reset();
      hdr = H1; loc = 1'b1;
      for (int i = 1; i <= TMO; i++) begin
         tick();
         n_chk++;
         if (vld !== 1'b1) begin n_fail++;
            $display("FAIL tmo_vld cyc %0d got %b exp 1", i, vld); end
      end
      tick();
      n_chk++;
      if ({vld, loc_ack} !== 2'b01) begin n_fail++;
         $display("FAIL tmo_abort got %b exp 01", {vld, loc_ack}); end
      n_chk++;
      if ({last_err, err_cnt, cmd_cnt} !== {2'b10, 4'd1, 4'd0}) begin
         n_fail++;
         $display("FAIL tmo_err got %h exp 210", {last_err, err_cnt, cmd_cnt});
      end
      loc = 1'b0;
      tick();
      loc = 1'b1;
      tick(); // N+1
      tick(); // N+2
      tick(); // N+3
      rdy = 1'b1;
      n_chk++;
      if (vld !== 1'b1) begin n_fail++;
         $display("FAIL tmo2_vld got %b exp 1", vld); end
      tick(); // N+4
      rdy = 1'b0;
      repeat (4) tick(); // N+8, timer at its limit
      done = 1'b1;
      tick();
      done = 1'b0;
      n_chk++;
      if (loc_ack !== 1'b1) begin n_fail++;
         $display("FAIL tmo2_ack got %b exp 1", loc_ack); end
      n_chk++;
      if ({last_err, err_cnt, cmd_cnt} !== {2'b00, 4'd1, 4'd1}) begin
         n_fail++;
         $display("FAIL tmo2_done_wins got %h exp 011", {last_err, err_cnt, cmd_cnt});
      end
      loc = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      hdr = H1; loc = 1'b1;
      tick();
      rdy = 1'b1;
      tick();
      rdy = 1'b0; net = 1'b1;
      n_chk++;
      if ({busy, vld} !== 2'b10) begin n_fail++;
         $display("FAIL rm_wait got %b exp 10", {busy, vld}); end
      rst_n = 1'b0;
      tick();
      n_chk++;
      if ({vld, loc_ack, net_ack, busy, grant} !== 5'b00001) begin n_fail++;
         $display("FAIL rm_clear got %b exp 00001", {vld, loc_ack, net_ack, busy, grant}); end
      rst_n = 1'b1; loc = 1'b0;
      tick();
      n_chk++;
      if ({grant, vld, loc_ack} !== 3'b110) begin n_fail++;
         $display("FAIL rm_net_grant got %b exp 110", {grant, vld, loc_ack}); end
      rdy = 1'b1;
      tick();
      rdy = 1'b0; done = 1'b1;
      tick();
      done = 1'b0;
      n_chk++;
      if ({loc_ack, net_ack, cmd_cnt} !== {2'b01, 4'd1}) begin n_fail++;
         $display("FAIL rm_net_ack got %h exp 11", {loc_ack, net_ack, cmd_cnt}); end
      net = 1'b0;
      tick();
   endtask

   task automatic test_counters();
      apply_reset();
      hdr = H1;
      for (int i = 0; i < 15; i++) run_good();
      n_chk++;
      if (cmd_cnt !== 4'd15) begin n_fail++;
         $display("FAIL cnt_15 got %0d exp 15", cmd_cnt); end
      run_good();
      n_chk++;
      if (cmd_cnt !== 4'd0) begin n_fail++;
         $display("FAIL cnt_wrap got %0d exp 0", cmd_cnt); end
      for (int i = 0; i < 15; i++) run_timeout();
      n_chk++;
      if (err_cnt !== 4'd15) begin n_fail++;
         $display("FAIL err_15 got %0d exp 15", err_cnt); end
      run_timeout();
      run_timeout();
      n_chk++;
      if ({err_cnt, cmd_cnt} !== {4'd15, 4'd0}) begin n_fail++;
         $display("FAIL err_sat got %h exp f0", {err_cnt, cmd_cnt}); end
   endtask

   initial begin
      rst_n = 1'b0;
      loc = 1'b0; net = 1'b0;
      rdy = 1'b0; done = 1'b0;
      hdr = '0; dat = '0;
      test_reset();
      test_local_only();
      test_round_robin();
      test_invalid();
      test_timeout();
      test_reset_mid();
      test_counters();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/qnet_cmd_arb.md
Name: qnet_cmd_arb

Overview:
- Sits downstream of the network command encoder in the t_clk_i domain.
- Arbitrates between the local-command and network-command request/ack pairs and issues the granted command (64-bit header + 2x32 data) to the TX packet engine.
- Tracks completion with a timeout and returns a four-phase ack to the granted requester.
- Exposes busy/grant/counter status for the AXI register map.

Parameters:
TIMEOUT_CYC, 4096, t_clk_i cycles allowed from issue to tx_done_i before abort (must be >=2)
CNT_W, 16, width of command/error counters

Ports:
t_clk_i  in  1  clock
t_rst_ni  in  1  synchronous reset, active-low
loc_cmd_req_i  in  1  local command request (level)
net_cmd_req_i  in  1  network command request (level)
header_i  in  64  shared command header, valid while any req high
data_i  in  2x32  shared command data words [0],[1]
loc_cmd_ack_o  out  1  local ack (level, four-phase)
net_cmd_ack_o  out  1  network ack (level, four-phase)
tx_vld_o  out  1  command valid to TX engine
tx_rdy_i  in  1  TX engine accepts command
tx_header_o  out  64  latched header
tx_data_o  out  2x32  latched data
tx_done_i  in  1  TX engine completion pulse
busy_o  out  1  state != IDLE
grant_o  out  1  last granted source: 0=loc, 1=net
cmd_cnt_o  out  CNT_W  completed commands, wraps
err_cnt_o  out  CNT_W  invalid + timeout events, saturates at all-ones
last_err_o  out  2  00 none, 01 invalid header, 10 timeout; held until next command completes

Behaviour:
- Reset (t_rst_ni low at clock edge): state IDLE; all outputs 0; grant_o=1 so first contested grant goes to loc; timer, counters and latched regs cleared. Reset mid-command drops tx_vld_o and acks next edge; no ack for the aborted command.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the source != grant_o (round-robin).
  - On grant: latch header_i/data_i, update grant_o, clear timer.
  - If header_i[63:61]==3'b000 (invalid CFG): go to ACK, last_err_o=01, err_cnt++, no issue.
  - Otherwise go to ISSUE.
- ISSUE:
  - tx_vld_o=1 with latched regs; outputs stable until tx_rdy_i.
  - tx_rdy_i=1 -> WAIT; tx_vld_o low next cycle.
- WAIT:
  - tx_done_i=1 -> ACK, cmd_cnt++, last_err_o=00.
  - tx_done_i arriving in the same cycle as tx_rdy_i is accepted: go directly to ACK.
  - tx_done_i outside WAIT (or that ISSUE cycle) is ignored.
- Timer:
  - Increments every cycle in ISSUE/WAIT.
  - On timer==TIMEOUT_CYC-1 without done/accept: go to ACK, tx_vld_o dropped, last_err_o=10, err_cnt++.
  - If done and timeout coincide, done wins.
- ACK:
  - Ack of granted source is high on every cycle in ACK.
  - When that source's req_i is low, ack drops next cycle and state returns to IDLE.
  - The other source's request is held pending and never lost.
  - A req staying high indefinitely holds ACK; this is legal with no timeout.
- Granted req dropping during ISSUE/WAIT: command completes normally; ACK then exits after one cycle.
- Latency, from req high in IDLE at cycle N:
  - tx_vld_o high at N+1.
  - Accept at cycle M -> WAIT at M+1.
  - Done at cycle K -> ack high at K+1.
  - Req low at cycle R -> ack low at R+1, IDLE at R+1.
  - The next grant can occur at R+1.
- Invalid header: ack high at N+1.
- Counters: cmd_cnt_o wraps all-ones -> 0; err_cnt_o saturates.

Test Plan:
1. Local only: header=0x9000_..._0001, data={0x11,0x22}; tx_rdy at N+3, done at N+6 -> tx_vld N+1..N+3, tx_header/data match, loc ack N+7 until req low, cmd_cnt=1, grant_o=0.
2. Both reqs high from reset:
   - Grant order is loc then net; the net header is taken from header_i at its grant cycle.
   - With both held, grants alternate loc,net,loc over 3 commands.
   - net_cmd_ack_o never asserts while loc is granted.
3. Invalid header (0x0000_...): loc req -> no tx_vld_o, ack at N+1, last_err=01, err_cnt=1, cmd_cnt unchanged.
4. TIMEOUT_CYC=8, tx_rdy never high:
   - tx_vld high 8 cycles then low.
   - Ack asserted, last_err=10, err_cnt=1.
   - Repeat with tx_rdy at cycle 3 and tx_done coinciding with timeout -> cmd_cnt++, last_err=00.
5. Reset asserted during WAIT -> next cycle all outputs 0, busy_o=0; after release a pending net req is granted normally.
6. Counter rollover: CNT_W=4, 16 good commands -> cmd_cnt 15 -> 0; 17 timeouts -> err_cnt held at 15.
